// File: rtl/spi_host.sv
// spi_host: Wishbone responder that runs an SPI mode-0, MSB-first host toward
// an external target. Four byte registers: DATA, STATUS, CTRL and a reserved slot.
// The serial engine is byte-wide; DATA_WIDTH is expected to stay at 8.
module spi_host #(
  parameter int                       WB_ADDR_WIDTH = 8,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [WB_ADDR_WIDTH-1:0] REG_BASE      = '0,
  parameter int                       CLK_DIV       = 4
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic                     wb_we_i,
  input  logic                     wb_cycle_i,
  input  logic                     wb_strobe_i,
  output logic                     wb_stall_o,
  output logic                     wb_ack_o,
  output logic                     spi_cs_no,
  output logic                     spi_sck_o,
  output logic                     spi_sd_o,
  input  logic                     spi_sd_i
);

  localparam int                   DIV_WIDTH = $clog2(CLK_DIV + 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LOAD  = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [2:0]           LAST_BIT  = 3'(DATA_WIDTH - 1);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [DIV_WIDTH-1:0]    div_count;
  logic [2:0]              bit_count;
  logic [DATA_WIDTH-1:0]   shift;
  logic [DATA_WIDTH-1:0]   rx;
  logic                    rx_valid;
  logic [DATA_WIDTH-1:0]   ctrl;
  logic                    ack;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    sd_out;

  logic                    hit;
  logic [1:0]              offset;
  logic                    busy;
  logic                    request;
  logic                    stall;
  logic                    accept;
  logic                    start;
  logic                    data_read;
  logic                    phase_end;
  logic                    rise;
  logic                    fall;
  logic [DATA_WIDTH-1:0]   read_value;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: walk LOW/HIGH half-periods for eight bits, then one DONE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOW;
      LOW:  if (phase_end) next_state = HIGH;
      HIGH: if (phase_end) next_state = (bit_count == LAST_BIT) ? DONE : LOW;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decode bus requests, SCK level and the phase strobes from the current state.
  always_comb begin
    hit        = (wb_addr_i[WB_ADDR_WIDTH-1:2] == REG_BASE[WB_ADDR_WIDTH-1:2]);
    offset     = wb_addr_i[1:0];
    busy       = (state != IDLE);
    request    = wb_cycle_i & wb_strobe_i & hit;
    stall      = request & busy & ((offset == OFF_DATA) | (offset == OFF_CTRL));
    accept     = request & ~stall;
    start      = accept & wb_we_i & (offset == OFF_DATA);
    data_read  = accept & ~wb_we_i & (offset == OFF_DATA);
    phase_end  = (div_count == '0);
    rise       = (state == LOW) & phase_end;
    fall       = (state == HIGH) & phase_end;
    wb_stall_o = stall;
    spi_sck_o  = (state == HIGH);
    case (offset)
      OFF_DATA:   read_value = rx;
      OFF_STATUS: read_value = {{(DATA_WIDTH-2){1'b0}}, rx_valid, busy};
      OFF_CTRL:   read_value = ctrl;
      default:    read_value = '0;
    endcase
  end

  // Datapath: divider, shifter, bit counter, RX capture, CTRL and bus response.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      div_count <= '0;
      bit_count <= '0;
      shift     <= '0;
      sd_out    <= 1'b0;
      rx        <= '0;
      rx_valid  <= 1'b0;
      ctrl      <= '0;
      ack       <= 1'b0;
      rdata     <= '0;
    end else begin
      ack   <= accept;
      rdata <= (accept & ~wb_we_i) ? read_value : '0;

      if (start | rise | fall) begin
        div_count <= DIV_LOAD;
      end else if ((state == LOW) || (state == HIGH)) begin
        div_count <= div_count - DIV_WIDTH'(1);
      end

      if (start) begin
        shift     <= wb_data_i;
        sd_out    <= wb_data_i[DATA_WIDTH-1];
        bit_count <= '0;
      end else if (rise) begin
        shift <= {shift[DATA_WIDTH-2:0], spi_sd_i};
      end else if (fall && (bit_count != LAST_BIT)) begin
        bit_count <= bit_count + 3'd1;
        sd_out    <= shift[DATA_WIDTH-1];
      end

      if (state == DONE) begin
        rx       <= shift;
        rx_valid <= 1'b1;
      end else if (data_read) begin
        rx_valid <= 1'b0;
      end

      if (accept & wb_we_i & (offset == OFF_CTRL)) begin
        ctrl <= wb_data_i;
      end
    end
  end

  assign wb_ack_o  = ack;
  assign wb_data_o = rdata;
  assign spi_sd_o  = sd_out;
  assign spi_cs_no = ~ctrl[0];

endmodule
